traffic_phase_controller: RTL and testbench

Sequencer for the two-road traffic intersection. Runs the four-phase light cycle from the programmed durations Tpv, Tsv and Ta, and derives a one-second tick from the 50 MHz system clock. Drives the phase code, countdown, road/pedestrian lamp codes and display phrase selection consumed by the output stage (LCD phrase bank, display control unit and model decoder).

---
 rtl/traffic_phase_controller_pkg.sv | 31 +++
 rtl/traffic_phase_controller_if.sv | 30 +++
 rtl/traffic_phase_controller_tick_gen.sv | 29 ++
 rtl/traffic_phase_controller.sv | 118 +++++++++++
 tb/tb_traffic_phase_controller.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_phase_controller_pkg.sv
// Shared types and constants for the intersection sequencer.
// Phase codes, lamp encodings and the duration saturation rule live here.
package traffic_pkg;

    typedef enum logic [1:0] {
        PV = 2'd0,
        PA = 2'd1,
        SV = 2'd2,
        SA = 2'd3
    } phase_t;

    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] AMBER = 3'b010;
    localparam logic [2:0] GREEN = 3'b001;

    localparam logic [1:0] P_RED   = 2'b10;
    localparam logic [1:0] P_GREEN = 2'b01;

    localparam logic [6:0] MAX_SECONDS = 7'd99;

    // A zero duration still shows one second so the cycle never stalls.
    function automatic logic [6:0] sat_seconds(input logic [6:0] x);
        if (x == 7'd0)
            return 7'd1;
        else if (x > MAX_SECONDS)
            return MAX_SECONDS;
        else
            return x;
    endfunction

endpackage

// File: rtl/traffic_phase_controller_if.sv
// Programming inputs, buttons and registered display/lamp outputs of the sequencer.
// The controller takes the slave side; the environment driving it takes the master side.
interface traffic_phase_controller_if;

    logic [6:0] Tpv;
    logic [6:0] Tsv;
    logic [6:0] Ta;
    logic       ped_req;
    logic       mode_btn;
    logic [1:0] StateFlag;
    logic [6:0] timeRemaining;
    logic [2:0] Principal_Road;
    logic [2:0] Secondary_Road;
    logic [1:0] Principal_Pedestrian;
    logic [1:0] Secondary_Pedestrian;
    logic [1:0] PhraseSel;

    modport master (
        output Tpv, Tsv, Ta, ped_req, mode_btn,
        input  StateFlag, timeRemaining, Principal_Road, Secondary_Road,
               Principal_Pedestrian, Secondary_Pedestrian, PhraseSel
    );

    modport slave (
        input  Tpv, Tsv, Ta, ped_req, mode_btn,
        output StateFlag, timeRemaining, Principal_Road, Secondary_Road,
               Principal_Pedestrian, Secondary_Pedestrian, PhraseSel
    );

endinterface

// File: rtl/traffic_phase_controller_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ clocks.
// The first tick is seen on the clock edge CLK_HZ/TICK_HZ cycles after reset release.
module tick_gen #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = (CLK_HZ / TICK_HZ > 1) ? CLK_HZ / TICK_HZ : 1;
    localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/traffic_phase_controller.sv
// Four-phase intersection sequencer: countdown, lamp codes, pedestrian truncation
// and display page selection, all driven from registers.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int PED_MIN = 5
) (
    input logic                         clock50MHz,
    input logic                         reset,
    traffic_phase_controller_if.slave   bus
);

    localparam logic [6:0] PED_LOAD = 7'(PED_MIN);

    phase_t     phase, phase_next;
    logic [6:0] remaining, remaining_next;
    logic [1:0] phrase, phrase_next;
    logic [2:0] road_p, road_p_next, road_s, road_s_next;
    logic [1:0] ped_p, ped_p_next, ped_s, ped_s_next;
    logic       ped_prev, mode_prev;
    logic       ped_rise, mode_rise;
    logic       tick;
    logic [6:0] load_pv, load_sv, load_a;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk  (clock50MHz),
        .rst  (reset),
        .tick (tick)
    );

    assign ped_rise  = bus.ped_req & ~ped_prev;
    assign mode_rise = bus.mode_btn & ~mode_prev;
    assign load_pv   = sat_seconds(bus.Tpv);
    assign load_sv   = sat_seconds(bus.Tsv);
    assign load_a    = sat_seconds(bus.Ta);

    always_ff @(posedge clock50MHz) begin
        if (reset) begin
            phase     <= PV;
            remaining <= load_pv;
            phrase    <= 2'd0;
            road_p    <= GREEN;
            road_s    <= RED;
            ped_p     <= P_RED;
            ped_s     <= P_GREEN;
            ped_prev  <= 1'b0;
            mode_prev <= 1'b0;
        end else begin
            phase     <= phase_next;
            remaining <= remaining_next;
            phrase    <= phrase_next;
            road_p    <= road_p_next;
            road_s    <= road_s_next;
            ped_p     <= ped_p_next;
            ped_s     <= ped_s_next;
            ped_prev  <= bus.ped_req;
            mode_prev <= bus.mode_btn;
        end
    end

    // A pedestrian truncation takes priority over a coincident tick.
    always_comb begin
        phase_next     = phase;
        remaining_next = remaining;
        phrase_next    = phrase;
        road_p_next    = RED;
        road_s_next    = RED;
        ped_p_next     = P_RED;
        ped_s_next     = P_RED;

        if (ped_rise && phase == PV && remaining > PED_LOAD) begin
            remaining_next = PED_LOAD;
        end else if (tick) begin
            if (remaining > 7'd1) begin
                remaining_next = remaining - 7'd1;
            end else begin
                phase_next = phase_t'(phase + 2'd1);
                if (phase_next == PV)
                    remaining_next = load_pv;
                else if (phase_next == SV)
                    remaining_next = load_sv;
                else
                    remaining_next = load_a;
            end
        end

        if (mode_rise)
            phrase_next = (phrase == 2'd2) ? 2'd0 : phrase + 2'd1;

        unique case (phase_next)
            PV: begin
                road_p_next = GREEN;
                ped_s_next  = P_GREEN;
            end
            PA: road_p_next = AMBER;
            SV: begin
                road_s_next = GREEN;
                ped_p_next  = P_GREEN;
            end
            SA: road_s_next = AMBER;
            default: ;
        endcase
    end

    assign bus.StateFlag            = phase;
    assign bus.timeRemaining        = remaining;
    assign bus.PhraseSel            = phrase;
    assign bus.Principal_Road       = road_p;
    assign bus.Secondary_Road       = road_s;
    assign bus.Principal_Pedestrian = ped_p;
    assign bus.Secondary_Pedestrian = ped_s;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Self-checking bench for traffic_phase_controller with a short tick period.
// A cycle-level behavioural model of the phase rules supplies every expected value.
module tb_traffic_phase_controller;

    localparam int CLK_HZ  = 20;
    localparam int TICK_HZ = 1;
    localparam int PED_MIN = 5;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    localparam logic [2:0] PROAD [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
    localparam logic [2:0] SROAD [4] = '{3'b100, 3'b100, 3'b001, 3'b010};
    localparam logic [1:0] PPED  [4] = '{2'b10, 2'b10, 2'b01, 2'b10};
    localparam logic [1:0] SPED  [4] = '{2'b01, 2'b10, 2'b10, 2'b10};

    logic clock50MHz = 1'b0;
    logic reset      = 1'b1;
    int   errors     = 0;
    int   checks     = 0;

    int m_phase  = 0;
    int m_rem    = 1;
    int m_phrase = 0;
    int m_cyc    = 0;
    bit m_ped_prev  = 1'b0;
    bit m_mode_prev = 1'b0;

    traffic_phase_controller_if bus ();

    traffic_phase_controller #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .PED_MIN (PED_MIN)
    ) dut (
        .clock50MHz (clock50MHz),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 clock50MHz = ~clock50MHz;

    function automatic int sat(input int x);
        if (x == 0) return 1;
        if (x > 99) return 99;
        return x;
    endfunction

    function automatic int duration(input int p);
        if (p == 0) return sat(int'(bus.Tpv));
        if (p == 2) return sat(int'(bus.Tsv));
        return sat(int'(bus.Ta));
    endfunction

    // Reference behaviour for one rising edge, using the inputs held across that edge.
    task automatic model_update();
        bit tick, ped_rise, mode_rise;
        if (reset) begin
            m_phase = 0; m_rem = sat(int'(bus.Tpv)); m_phrase = 0; m_cyc = 0;
            m_ped_prev = 1'b0; m_mode_prev = 1'b0;
            return;
        end
        m_cyc++;
        tick      = (m_cyc % DIV == 0);
        ped_rise  = bus.ped_req && !m_ped_prev;
        mode_rise = bus.mode_btn && !m_mode_prev;
        if (ped_rise && m_phase == 0 && m_rem > PED_MIN)
            m_rem = PED_MIN;
        else if (tick) begin
            if (m_rem > 1) m_rem--;
            else begin
                m_phase = (m_phase + 1) % 4;
                m_rem   = duration(m_phase);
            end
        end
        if (mode_rise) m_phrase = (m_phrase + 1) % 3;
        m_ped_prev  = bus.ped_req;
        m_mode_prev = bus.mode_btn;
    endtask

    function automatic logic [20:0] model_vec();
        return {2'(m_phase), 7'(m_rem), PROAD[m_phase], SROAD[m_phase],
                PPED[m_phase], SPED[m_phase], 2'(m_phrase)};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {bus.StateFlag, bus.timeRemaining, bus.Principal_Road, bus.Secondary_Road,
                bus.Principal_Pedestrian, bus.Secondary_Pedestrian, bus.PhraseSel};
    endfunction

    task automatic cycle();
        @(posedge clock50MHz);
        model_update();
        @(negedge clock50MHz);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input int tpv, input int tsv, input int ta);
        bus.Tpv = 7'(tpv);
        bus.Tsv = 7'(tsv);
        bus.Ta  = 7'(ta);
    endtask

    task automatic test_reset();
        applyStimulus(3, 2, 1);
        bus.ped_req = 1'b0; bus.mode_btn = 1'b0;
        reset = 1'b1;
        cycle(); cycle();
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected %h", dut_vec(), model_vec());
        end
        checks++;
        if (dut_vec() !== {2'd0, 7'd3, 3'b001, 3'b100, 2'b10, 2'b01, 2'd0}) begin
            errors++;
            $display("[TB] FAIL reset_constants: got %h expected %h", dut_vec(),
                     {2'd0, 7'd3, 3'b001, 3'b100, 2'b10, 2'b01, 2'd0});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_cycle();
        int seq_code = 0, len_code = 0, pv_code = 3, last_change = 0;
        logic [1:0] prev_phase = 2'd0;
        logic [6:0] prev_rem = 7'd3;
        applyStimulus(3, 2, 1);
        apply_reset();
        for (int i = 1; i <= 7 * DIV; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL basic_cycle@%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
            if (bus.StateFlag !== prev_phase) begin
                seq_code = seq_code * 10 + int'(bus.StateFlag);
                len_code = len_code * 10 + (i - last_change) / DIV;
                last_change = i;
                prev_phase = bus.StateFlag;
            end
            if (bus.StateFlag == 2'd0 && i < 3 * DIV && bus.timeRemaining !== prev_rem) begin
                pv_code = pv_code * 10 + int'(bus.timeRemaining);
                prev_rem = bus.timeRemaining;
            end
        end
        checks++;
        if (seq_code != 1230) begin
            errors++;
            $display("[TB] FAIL phase_sequence: got 0%0d expected 01230", seq_code);
        end
        checks++;
        if (len_code != 3121) begin
            errors++;
            $display("[TB] FAIL phase_lengths: got %0d expected 3121", len_code);
        end
        checks++;
        if (pv_code != 321) begin
            errors++;
            $display("[TB] FAIL pv_countdown: got %0d expected 321", pv_code);
        end
    endtask

    task automatic test_saturation();
        applyStimulus(0, 120, 2);
        apply_reset();
        checks++;
        if (bus.timeRemaining !== 7'd1) begin
            errors++;
            $display("[TB] FAIL sat_zero: got %0d expected 1", bus.timeRemaining);
        end
        for (int i = 1; i <= 3 * DIV; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL saturation@%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        checks++;
        if (bus.StateFlag !== 2'd2 || bus.timeRemaining !== 7'd99) begin
            errors++;
            $display("[TB] FAIL sat_99: got phase %0d time %0d expected phase 2 time 99",
                     bus.StateFlag, bus.timeRemaining);
        end
        applyStimulus(2, 1, 2);
        apply_reset();
        for (int i = 1; i <= 9 * DIV; i++) begin
            cycle();
            if (i == 50) bus.Ta = 7'd4;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL ta_change@%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
            if (i == 4 * DIV) begin
                checks++;
                if (bus.StateFlag !== 2'd2) begin
                    errors++;
                    $display("[TB] FAIL pa_length_kept: got phase %0d expected 2", bus.StateFlag);
                end
            end
            if (i == 5 * DIV) begin
                checks++;
                if (bus.StateFlag !== 2'd3 || bus.timeRemaining !== 7'd4) begin
                    errors++;
                    $display("[TB] FAIL sa_new_ta: got phase %0d time %0d expected phase 3 time 4",
                             bus.StateFlag, bus.timeRemaining);
                end
            end
        end
        checks++;
        if (bus.StateFlag !== 2'd0) begin
            errors++;
            $display("[TB] FAIL sa_length: got phase %0d expected 0", bus.StateFlag);
        end
    endtask

    task automatic test_pedestrian();
        applyStimulus(20, 9, 1);
        apply_reset();
        for (int i = 1; i <= 260; i++) begin
            if (i == 161) bus.ped_req = 1'b1;
            if (i == 164) bus.ped_req = 1'b0;
            cycle();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL pedestrian@%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
            if (i == 160 || i == 161) begin
                checks++;
                if (bus.timeRemaining !== ((i == 160) ? 7'd12 : 7'd5)) begin
                    errors++;
                    $display("[TB] FAIL ped_truncate@%0d: got %0d expected %0d", i,
                             bus.timeRemaining, (i == 160) ? 12 : 5);
                end
            end
        end
        checks++;
        if (bus.StateFlag !== 2'd1) begin
            errors++;
            $display("[TB] FAIL ped_to_pa: got phase %0d expected 1", bus.StateFlag);
        end
        applyStimulus(4, 9, 1);
        apply_reset();
        for (int i = 1; i <= 106; i++) begin
            bus.ped_req = (i == 6 || i == 106);
            cycle();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL ped_ignore@%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
            if (i == 6 || i == 106) begin
                checks++;
                if (bus.timeRemaining !== ((i == 6) ? 7'd4 : 7'd9)) begin
                    errors++;
                    $display("[TB] FAIL ped_ignored@%0d: got %0d expected %0d", i,
                             bus.timeRemaining, (i == 6) ? 4 : 9);
                end
            end
        end
        bus.ped_req = 1'b0;
    endtask

    task automatic test_coincidence();
        applyStimulus(20, 3, 1);
        apply_reset();
        for (int i = 1; i <= 240; i++) begin
            bus.ped_req = (i == 220);
            cycle();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL coincidence@%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
            if (i == 219 || i == 220 || i == 240) begin
                checks++;
                if (bus.timeRemaining !== ((i == 219) ? 7'd10 : (i == 220) ? 7'd5 : 7'd4)) begin
                    errors++;
                    $display("[TB] FAIL tick_vs_ped@%0d: got %0d expected %0d", i, bus.timeRemaining,
                             (i == 219) ? 10 : (i == 220) ? 5 : 4);
                end
            end
        end
        bus.ped_req = 1'b0;
    endtask

    task automatic test_display_mode();
        int exp_ph [4] = '{1, 2, 0, 1};
        applyStimulus(5, 5, 2);
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            bus.mode_btn = 1'b1;
            cycle();
            checks++;
            if (bus.PhraseSel !== 2'(exp_ph[k]) || dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL phrase_step%0d: got %h expected %h", k, dut_vec(), model_vec());
            end
            bus.mode_btn = 1'b0;
            cycle(); cycle();
        end
        bus.mode_btn = 1'b1;
        for (int i = 0; i < 100; i++) cycle();
        bus.mode_btn = 1'b0;
        cycle();
        checks++;
        if (bus.PhraseSel !== 2'd2 || dut_vec() !== model_vec()) begin
            errors++;
            $display("[TB] FAIL phrase_held: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_reset_mid_sv();
        int guard = 0;
        bit stayed = 1'b1;
        applyStimulus(2, 9, 1);
        apply_reset();
        bus.mode_btn = 1'b1;
        cycle();
        bus.mode_btn = 1'b0;
        while (!(m_phase == 2 && m_rem == 7 && (m_cyc % DIV) == DIV - 1) && guard < 1000) begin
            cycle();
            guard++;
        end
        checks++;
        if (guard >= 1000 || dut_vec() !== model_vec()) begin
            errors++;
            $display("[TB] FAIL reach_sv7: got %h expected %h after %0d cycles", dut_vec(), model_vec(), guard);
        end
        apply_reset();
        checks++;
        if (bus.StateFlag !== 2'd0 || bus.timeRemaining !== 7'd2 || bus.PhraseSel !== 2'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got phase %0d time %0d page %0d expected 0 2 0",
                     bus.StateFlag, bus.timeRemaining, bus.PhraseSel);
        end
        for (int i = 1; i < DIV; i++) begin
            cycle();
            if (bus.timeRemaining !== 7'd2) stayed = 1'b0;
        end
        checks++;
        if (!stayed) begin
            errors++;
            $display("[TB] FAIL early_tick: got a tick before %0d cycles expected none", DIV);
        end
        cycle();
        checks++;
        if (bus.timeRemaining !== 7'd1) begin
            errors++;
            $display("[TB] FAIL first_tick: got %0d expected 1", bus.timeRemaining);
        end
    endtask

    task automatic test_random();
        applyStimulus($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 4));
        apply_reset();
        for (int i = 1; i <= 1500; i++) begin
            if (i % 250 == 0) begin
                applyStimulus(($urandom_range(0, 7) == 0) ? $urandom_range(100, 127) : $urandom_range(0, 12),
                              $urandom_range(0, 10), $urandom_range(0, 5));
            end
            bus.ped_req  = ($urandom_range(0, 9) == 0);
            bus.mode_btn = ($urandom_range(0, 7) == 0);
            cycle();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL random@%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        bus.ped_req = 1'b0; bus.mode_btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_cycle();
        test_saturation();
        test_pedestrian();
        test_coincidence();
        test_display_mode();
        test_reset_mid_sv();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
